// File: rtl/cfg_shadow_bank.sv
// Shadow/active configuration register bank. Writes land in shadow registers;
// a commit write copies shadow->active one register per cycle while back-pressuring.

module cfg_shadow_slot #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       shadow_we,
   input  logic       copy_en,
   input  logic [7:0] dat,
   output logic [7:0] active
);

   logic [7:0] shadow;

   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow <= RESET_VAL;
         active <= RESET_VAL;
      end else begin
         if (shadow_we) shadow <= dat;
         if (copy_en)   active <= shadow;
      end
   end

endmodule

module cfg_shadow_bank #(
   parameter int         NREGS       = 8,
   parameter logic [7:0] COMMIT_ADDR = 8'hFF,
   parameter logic [7:0] RESET_VAL   = 8'h00,
   parameter int         ERRW        = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [7:0]            cfg_addr,
   input  logic [7:0]            cfg_dat,
   output logic                  cfg_busy,
   output logic [8*NREGS-1:0]    active_regs,
   output logic                  commit_done,
   output logic [ERRW-1:0]       err_cnt
);

   localparam int         IDXW     = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREGS - 1);
   localparam logic [7:0] NREGS8   = 8'(NREGS);

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] dat;
   } cfg_req_t;

   typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

   cfg_req_t        req;
   state_t          state, state_nxt;
   logic [IDXW-1:0] idx, idx_nxt;
   logic            in_range, is_commit;
   logic            take_wr, take_commit, drop;

   assign req = '{we: cfg_we, addr: cfg_addr, dat: cfg_dat};

   // Address 0 is deliberately unmapped so that a zeroed bus never writes a register.
   assign in_range    = (req.addr != 8'd0) && (req.addr <= NREGS8);
   assign is_commit   = (req.addr == COMMIT_ADDR);
   assign take_wr     = req.we && (state == IDLE) && in_range;
   assign take_commit = req.we && (state == IDLE) && is_commit;
   assign drop        = req.we && !(take_wr || take_commit);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (take_commit) begin
               state_nxt = COPY;
               idx_nxt   = '0;
            end
         end
         COPY: begin
            if (idx == IDX_LAST) state_nxt = DONE;
            else                 idx_nxt   = idx + IDXW'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it exactly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         cfg_busy    <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         cfg_busy    <= (state_nxt != IDLE);
         commit_done <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_cnt <= '0;
      end else if (drop && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERRW'(1);
      end
   end

   genvar i;
   generate
      for (i = 0; i < NREGS; i++) begin : g_slot
         cfg_shadow_slot #(
            .RESET_VAL (RESET_VAL)
         ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .shadow_we (take_wr && (req.addr == 8'(i + 1))),
            .copy_en   ((state == COPY) && (idx == IDXW'(i))),
            .dat       (req.dat),
            .active    (active_regs[8*i +: 8])
         );
      end
   endgenerate

endmodule

// File: tb/tb_cfg_shadow_bank.sv
// Directed bench for cfg_shadow_bank: commits are scoreboarded and checked
// by a monitor on commit_done; status and per-cycle behaviour checked inline.

module tb_cfg_shadow_bank;

   localparam int NREGS = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cfg_we = 1'b0;
   logic             sat_we = 1'b0;
   logic [7:0]       cfg_addr = 8'h00;
   logic [7:0]       cfg_dat = 8'h00;
   logic             cfg_busy, commit_done;
   logic [8*NREGS-1:0] active_regs;
   logic [7:0]       err_cnt;
   logic             busy2, done2;
   logic [8*NREGS-1:0] active2;
   logic [1:0]       err2;

   cfg_shadow_bank #(.NREGS(NREGS), .COMMIT_ADDR(8'hFF), .RESET_VAL(8'h00), .ERRW(8)) u_dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dat(cfg_dat),
      .cfg_busy(cfg_busy), .active_regs(active_regs), .commit_done(commit_done), .err_cnt(err_cnt));

   cfg_shadow_bank #(.NREGS(NREGS), .COMMIT_ADDR(8'hFF), .RESET_VAL(8'h00), .ERRW(2)) u_sat (
      .clk(clk), .reset(reset), .cfg_we(sat_we), .cfg_addr(cfg_addr), .cfg_dat(cfg_dat),
      .cfg_busy(busy2), .active_regs(active2), .commit_done(done2), .err_cnt(err2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] regs;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      cfg_addr = a;
      cfg_dat  = d;
      cfg_we   = 1'b1;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic commit(input logic [63:0] exp);
      exp_t e;
      wr(8'hFF, 8'h5A);
      e.regs = exp;
      e.cyc  = cyc + NREGS;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (cfg_busy && n < 50) begin
         step();
         n++;
      end
      chk("idle_timeout", cfg_busy, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset && commit_done) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_commit_done: got pulse at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            chk("commit_regs", active_regs, e.regs);
            chk("commit_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      // reset held 2 clocks with a live write that must be ignored
      reset    = 1'b0;
      cfg_we   = 1'b1;
      cfg_addr = 8'd5;
      cfg_dat  = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      cfg_we = 1'b0;
      reset  = 1'b1;
      chk("rst_active", active_regs, 64'h0);
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_done", commit_done, 1'b0);
      chk("rst_err", err_cnt, 8'd0);
      chk("rst_err_sat", err2, 2'd0);

      // shadow writes stay invisible until commit
      wr(8'd1, 8'hA5);
      wr(8'd2, 8'h3C);
      step();
      chk("shadow_iso", active_regs, 64'h0);

      // commit: busy for NREGS+1 cycles, one register per cycle
      commit(64'h0000_0000_0000_3CA5);
      for (int k = 0; k < 10; k++) begin
         chk("commit_busy", cfg_busy, (k < 9) ? 1'b1 : 1'b0);
         chk("commit_a0", active_regs[7:0], (k >= 1) ? 8'hA5 : 8'h00);
         chk("commit_a1", active_regs[15:8], (k >= 2) ? 8'h3C : 8'h00);
         step();
      end

      // dropped writes: addr 0, addr NREGS+1, in-range write while busy
      wr(8'd0, 8'h11);
      wr(8'd9, 8'h22);
      commit(64'h0000_0000_0000_3CA5);
      wr(8'd3, 8'h77);
      wait_idle();
      chk("drop_err", err_cnt, 8'd3);
      commit(64'h0000_0000_0000_3CA5);
      wait_idle();
      chk("drop_err_hold", err_cnt, 8'd3);

      // top register, then back-to-back commits
      wr(8'd8, 8'hC3);
      commit(64'hC300_0000_0000_3CA5);
      wait_idle();
      commit(64'hC300_0000_0000_3CA5);
      wait_idle();

      // saturation on the 2-bit counter instance
      cfg_addr = 8'd0;
      for (int k = 0; k < 5; k++) begin
         sat_we = 1'b1;
         step();
         sat_we = 1'b0;
         if (k == 2) chk("sat_err_3", err2, 2'd3);
      end
      chk("sat_err_5", err2, 2'd3);
      chk("sat_main_err", err_cnt, 8'd3);

      // reset sampled at edge T+3 of a commit
      wr(8'd1, 8'h11);
      wr(8'd2, 8'h22);
      wr(8'hFF, 8'h00);
      step();
      step();
      chk("midcommit_progress", active_regs, 64'hC300_0000_0000_2211);
      reset = 1'b0;
      step();
      chk("midrst_active", active_regs, 64'h0);
      chk("midrst_busy", cfg_busy, 1'b0);
      chk("midrst_done", commit_done, 1'b0);
      chk("midrst_err", err_cnt, 8'd0);
      reset = 1'b1;
      repeat (12) step();
      chk("midrst_idle", cfg_busy, 1'b0);

      // shadows were cleared by reset too
      commit(64'h0);
      wait_idle();

      repeat (3) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
